// File: rtl/spi_bitrev_slave_if.sv
// SPI pin bundle for the bit-reversing slave.
// Master drives sck/ss/mosi; the slave returns miso.
interface spi_bitrev_slave_if;
  logic sck;
  logic ss;
  logic mosi;
  logic miso;

  modport master (
    output sck,
    output ss,
    output mosi,
    input  miso
  );

  modport slave (
    input  sck,
    input  ss,
    input  mosi,
    output miso
  );
endinterface

// File: rtl/spi_bitrev_slave.sv
// System-clocked SPI mode-0 slave: receives a word, then returns it
// bit-reversed (or echoed) over the next WIDTH SCK cycles.
module spi_bitrev_slave #(
  parameter int WIDTH       = 8,
  parameter bit REVERSE     = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  spi_bitrev_slave_if.slave    spi,
  output logic                 rx_valid,
  output logic [WIDTH-1:0]     rx_data,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 busy
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_d_q;

  state_e                 state_q, state_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                   miso_q, miso_d;

  logic                   sck_s, ss_s, mosi_s;
  logic                   rise, fall;
  logic [WIDTH-1:0]       word, word_rev;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sck_s & ~sck_d_q;
  assign fall   = ~sck_s & sck_d_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi.sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi.ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
  end

  // Word as it stands once the bit arriving on this rise is included.
  always_comb begin
    word = {rx_shift_q[WIDTH-2:0], mosi_s};
    word_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_rev[i] = word[WIDTH-1-i];
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    miso_d      = miso_q;
    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (!ss_s) begin
          state_d    = RX;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end
      end
      RX: begin
        if (ss_s) begin
          state_d   = IDLE;
          miso_d    = 1'b1;
          bit_cnt_d = '0;
        end else if (rise) begin
          rx_shift_d = word;
          bit_cnt_d  = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST) begin
            rx_data_d  = word;
            rx_valid_d = 1'b1;
            tx_shift_d = REVERSE ? word_rev : word;
            bit_cnt_d  = '0;
            state_d    = TX;
          end
        end else if (fall) begin
          miso_d = 1'b1;
        end
      end
      TX: begin
        if (ss_s) begin
          state_d   = IDLE;
          miso_d    = 1'b1;
          bit_cnt_d = '0;
        end else if (fall) begin
          miso_d     = tx_shift_q[WIDTH-1];
          tx_shift_d = tx_shift_q << 1;
        end else if (rise) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST) begin
            bit_cnt_d   = '0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = RX;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        miso_d    = 1'b1;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_d_q     <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_cnt_q <= '0;
      miso_q      <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_d_q     <= sck_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_cnt_q <= frame_cnt_d;
      miso_q      <= miso_d;
    end
  end

  assign spi.miso  = miso_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
